// File: rtl/switch_arbiter_if.sv
// Handshake bundle between the port queues, the arbiter and the output word path.
interface switch_arbiter_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned SEL_W  = $clog2(NPORTS)
);
  logic [NPORTS-1:0] req;
  logic              out_ready;
  logic [NPORTS-1:0] grant;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              word_en;
  logic              last;
  logic              frame_done;

  // Arbiter side.
  modport master (
    input  req, out_ready,
    output grant, sel, busy, word_en, last, frame_done
  );

  // Port-queue / datapath side.
  modport slave (
    output req, out_ready,
    input  grant, sel, busy, word_en, last, frame_done
  );
endinterface

// File: rtl/switch_arbiter.sv
// Round-robin packet scheduler: grants one port, sequences WORDS word transfers
// under output backpressure, then releases the grant and rotates priority.
module switch_arbiter #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SEL_W  = $clog2(NPORTS),
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  switch_arbiter_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(WORDS - 1);
  localparam logic [SEL_W-1:0]  LgReset = SEL_W'(NPORTS - 1);
  localparam logic [NPORTS-1:0] OneHot0 = NPORTS'(1);

  state_e            state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  lg_q, lg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_done_q, frame_done_d;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic              word_en;
  logic              last;

  // First requester searching upward from the port after the last-granted one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      if (!pick_found && bus.req[SEL_W'((32'(lg_q) + i) % NPORTS)]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'((32'(lg_q) + i) % NPORTS);
      end
    end
  end

  // Next-state, word sequencing and combinational transfer strobes.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    lg_d         = lg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    word_en      = 1'b0;
    last         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = OneHot0 << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Counter only advances on accepted words; stalls are unbounded.
        if (bus.out_ready) begin
          word_en = 1'b1;
          if (cnt_q == LastCnt) begin
            last         = 1'b1;
            grant_d      = '0;
            cnt_d        = '0;
            frame_done_d = 1'b1;
            state_d      = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        // Priority rotates only for completed packets.
        lg_d    = sel_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; async reset abandons any packet in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      sel_q        <= '0;
      lg_q         <= LgReset;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      lg_q         <= lg_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.word_en    = word_en;
  assign bus.last       = last;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: a 4-port/4-word instance plus a
// 2-port/1-word instance sharing clock and reset.
module tb_switch_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  switch_arbiter_if #(.NPORTS(4)) bus4 ();
  switch_arbiter_if #(.NPORTS(2)) bus2 ();

  switch_arbiter #(.NPORTS(4), .WORDS(4)) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4)
  );

  switch_arbiter #(.NPORTS(2), .WORDS(1)) u_dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (bus4.grant !== 4'b0000) begin
      n_err++; $display("FAIL reset_grant: got %b want 0000", bus4.grant);
    end
    n_vec++;
    if (bus4.sel !== 2'd0) begin
      n_err++; $display("FAIL reset_sel: got %0d want 0", bus4.sel);
    end
    n_vec++;
    if ({bus4.busy, bus4.frame_done, bus4.word_en, bus4.last} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus4.busy, bus4.frame_done, bus4.word_en, bus4.last});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus4.req = 4'b0001; bus4.out_ready = 1'b1; #1;
    n_vec++;
    if (bus4.grant !== 4'b0000 || bus4.word_en !== 1'b0) begin
      n_err++; $display("FAIL single_idle: grant %b word_en %b want 0000 0", bus4.grant, bus4.word_en);
    end
    tick();
    bus4.req = 4'b0000;
    n_vec++;
    if (bus4.grant !== 4'b0001 || bus4.busy !== 1'b1) begin
      n_err++; $display("FAIL single_grant: grant %b busy %b want 0001 1", bus4.grant, bus4.busy);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (bus4.word_en !== 1'b1 || bus4.last !== (k == 3)) begin
        n_err++;
        $display("FAIL single_word%0d: word_en %b last %b want 1 %b", k, bus4.word_en, bus4.last, k == 3);
      end
      tick();
    end
    n_vec++;
    if (bus4.frame_done !== 1'b1 || bus4.grant !== 4'b0000 || bus4.busy !== 1'b1
        || bus4.word_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: fd %b grant %b busy %b we %b want 1 0000 1 0",
               bus4.frame_done, bus4.grant, bus4.busy, bus4.word_en);
    end
    tick();
    n_vec++;
    if (bus4.frame_done !== 1'b0 || bus4.busy !== 1'b0 || bus4.grant !== 4'b0000) begin
      n_err++;
      $display("FAIL single_idle_after: fd %b busy %b grant %b want 0 0 0000",
               bus4.frame_done, bus4.busy, bus4.grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    bus4.req = 4'b1111; bus4.out_ready = 1'b1;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      if (g == 4) bus4.req = 4'b0000;
      n_vec++;
      if (bus4.grant !== exp || bus4.sel !== 2'(g % 4)) begin
        n_err++; $display("FAIL rr_grant%0d: grant %b sel %0d want %b %0d", g, bus4.grant, bus4.sel, exp, g % 4);
      end
      for (int w = 0; w < 4; w++) begin
        n_vec++;
        if (bus4.word_en !== 1'b1 || bus4.last !== (w == 3)) begin
          n_err++;
          $display("FAIL rr_word%0d_%0d: word_en %b last %b want 1 %b", g, w, bus4.word_en, bus4.last, w == 3);
        end
        tick();
      end
      n_vec++;
      if (bus4.frame_done !== 1'b1 || bus4.grant !== 4'b0000) begin
        n_err++; $display("FAIL rr_done%0d: fd %b grant %b want 1 0000", g, bus4.frame_done, bus4.grant);
      end
      tick();
      n_vec++;
      if (bus4.grant !== 4'b0000 || bus4.busy !== 1'b0) begin
        n_err++; $display("FAIL rr_idle%0d: grant %b busy %b want 0000 0", g, bus4.grant, bus4.busy);
      end
      if (g < 4) tick();
    end
  endtask

  task automatic test_backpressure();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus4.req = 4'b0001; bus4.out_ready = 1'b1;
    tick();
    bus4.req = 4'b0000;
    n_vec++;
    if (bus4.grant !== 4'b0001) begin
      n_err++; $display("FAIL bp_grant: got %b want 0001", bus4.grant);
    end
    for (int i = 0; i < 7; i++) begin
      bus4.out_ready = pat[i]; #1;
      n_vec++;
      if (bus4.word_en !== pat[i] || bus4.last !== (i == 6) || bus4.busy !== 1'b1) begin
        n_err++;
        $display("FAIL bp_cycle%0d: word_en %b last %b busy %b want %b %b 1",
                 i, bus4.word_en, bus4.last, bus4.busy, pat[i], i == 6);
      end
      tick();
    end
    n_vec++;
    if (bus4.frame_done !== 1'b1 || bus4.grant !== 4'b0000) begin
      n_err++; $display("FAIL bp_done: fd %b grant %b want 1 0000", bus4.frame_done, bus4.grant);
    end
    bus4.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    bus4.req = 4'b0010; bus4.out_ready = 1'b1;
    tick();
    n_vec++;
    if (bus4.grant !== 4'b0010) begin
      n_err++; $display("FAIL rm_grant: got %b want 0010", bus4.grant);
    end
    tick();
    tick();
    rst_n = 1'b0; #1;
    n_vec++;
    if (bus4.grant !== 4'b0000 || bus4.busy !== 1'b0 || bus4.frame_done !== 1'b0
        || bus4.word_en !== 1'b0 || bus4.sel !== 2'd0) begin
      n_err++;
      $display("FAIL rm_async: grant %b busy %b fd %b we %b sel %0d want 0000 0 0 0 0",
               bus4.grant, bus4.busy, bus4.frame_done, bus4.word_en, bus4.sel);
    end
    tick();
    n_vec++;
    if (bus4.frame_done !== 1'b0) begin
      n_err++; $display("FAIL rm_no_done: fd %b want 0", bus4.frame_done);
    end
    rst_n = 1'b1;
    bus4.req = 4'b1111; #1;
    n_vec++;
    if (bus4.grant !== 4'b0000) begin
      n_err++; $display("FAIL rm_idle: grant %b want 0000", bus4.grant);
    end
    tick();
    bus4.req = 4'b0000;
    n_vec++;
    if (bus4.grant !== 4'b0001 || bus4.sel !== 2'd0) begin
      n_err++; $display("FAIL rm_regrant: grant %b sel %0d want 0001 0", bus4.grant, bus4.sel);
    end
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_req_drop();
    bus4.req = 4'b1100; bus4.out_ready = 1'b1;
    tick();
    n_vec++;
    if (bus4.grant !== 4'b0100 || bus4.word_en !== 1'b1) begin
      n_err++; $display("FAIL rd_grant: grant %b we %b want 0100 1", bus4.grant, bus4.word_en);
    end
    tick();
    bus4.req = 4'b1001;
    for (int w = 0; w < 3; w++) begin
      n_vec++;
      if (bus4.word_en !== 1'b1 || bus4.last !== (w == 2) || bus4.grant !== 4'b0100) begin
        n_err++;
        $display("FAIL rd_word%0d: we %b last %b grant %b want 1 %b 0100",
                 w, bus4.word_en, bus4.last, bus4.grant, w == 2);
      end
      tick();
    end
    n_vec++;
    if (bus4.frame_done !== 1'b1) begin
      n_err++; $display("FAIL rd_done: fd %b want 1", bus4.frame_done);
    end
    tick();
    tick();
    bus4.req = 4'b0000;
    n_vec++;
    if (bus4.grant !== 4'b1000 || bus4.sel !== 2'd3) begin
      n_err++; $display("FAIL rd_next: grant %b sel %0d want 1000 3", bus4.grant, bus4.sel);
    end
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_words1();
    logic [1:0] exp;
    bus2.req = 2'b11; bus2.out_ready = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp = (g % 2 == 0) ? 2'b01 : 2'b10;
      n_vec++;
      if (bus2.grant !== exp || bus2.word_en !== 1'b1 || bus2.last !== 1'b1) begin
        n_err++;
        $display("FAIL w1_beat%0d: grant %b we %b last %b want %b 1 1",
                 g, bus2.grant, bus2.word_en, bus2.last, exp);
      end
      tick();
      n_vec++;
      if (bus2.frame_done !== 1'b1 || bus2.grant !== 2'b00) begin
        n_err++; $display("FAIL w1_done%0d: fd %b grant %b want 1 00", g, bus2.frame_done, bus2.grant);
      end
      tick();
      n_vec++;
      if (bus2.grant !== 2'b00 || bus2.busy !== 1'b0) begin
        n_err++; $display("FAIL w1_idle%0d: grant %b busy %b want 00 0", g, bus2.grant, bus2.busy);
      end
      if (g < 3) tick();
    end
    bus2.req = 2'b00;
    tick();
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    bus4.req       = '0;
    bus4.out_ready = 1'b0;
    bus2.req       = '0;
    bus2.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_req_drop();
    test_words1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Round-robin scheduler that shares the packet switcher's single output datapath among NPORTS input ports. It grants one requesting port at a time, sequences exactly WORDS word transfers for that port under output backpressure, then releases the grant and advances priority. It sits between the input port queues and the output word path, and replaces ad-hoc per-port word counting with one central sequencer.

## Interface
- NPORTS, 4: number of requesting ports; supported range 2..8.
- WORDS, 4: words per packet; supported range 1..256.
- SEL_W, clog2(NPORTS): width of `sel`.
- CNT_W, 8: width of the internal word counter; must satisfy 2^CNT_W >= WORDS.

- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NPORTS  per-port packet request; held high by the port until `frame_done`.
- out_ready  input  1  output datapath can accept a word this cycle.
- grant  output  NPORTS  one-hot grant of the selected port, registered; all-zero when idle.
- sel  output  SEL_W  binary index of the granted port, registered; holds its last value when idle.
- busy  output  1  high while a packet is in flight (state XFER or DONE).
- word_en  output  1  combinational; high = one word moves this cycle (XFER and out_ready).
- last  output  1  combinational; high with `word_en` on the final word of the packet.
- frame_done  output  1  registered one-cycle pulse after the final word.

## Operation
- States: IDLE, XFER, DONE.
- IDLE: if any `req` bit is high, select the first requesting port searching upward (modulo NPORTS) from `lg+1`, where `lg` is the last-granted index. Load `grant`/`sel`, clear counter, enter XFER. If no request, stay in IDLE with `grant`=0.
- XFER: `word_en` = `out_ready`. Each cycle with `word_en`, counter increments. When counter == WORDS-1 and `out_ready`, `last`=1. On the next edge, go to DONE.
- Counter stalls while `out_ready`=0. No timeout.
- DONE: `grant` cleared, `lg` <= `sel`, `frame_done`=1 for this cycle only. Next edge returns to IDLE.
- A packet is committed once granted. A `req` drop during XFER is ignored, and all WORDS words are still sequenced.
- `req` changes in DONE are not sampled. Arbitration happens only in IDLE.
- WORDS=1: the first accepted beat is also `last`.
- Reset values: state IDLE, `grant`=0, `sel`=0, `busy`=0, `frame_done`=0, counter=0, `lg`=NPORTS-1 (port 0 wins first).
- Reset asserted mid-packet: everything returns to reset values immediately, asynchronously. The partial packet is abandoned and no `frame_done` is issued.

## Timing
- Request to grant: `req` high in an IDLE cycle gives `grant` high on the following cycle. The first `word_en` is possible in that same cycle.
- Minimum packet occupancy: WORDS cycles in XFER plus 1 in DONE plus 1 in IDLE, i.e. WORDS+2 cycles between consecutive grants with `out_ready` held high.
- `frame_done` is high exactly one cycle after the `last` cycle and coincides with `grant`=0 and `busy`=1.
- `busy` rises with `grant` and falls one cycle after `frame_done`.
- `word_en` and `last` are never high outside XFER. `grant` is always one-hot or zero.
- Reset deassertion is synchronized externally. The first arbitration occurs on the first edge after release.

## Test plan
- Single request, WORDS=4: `req`=0001, `out_ready`=1 -> `grant`=0001 one cycle later, then 4 consecutive `word_en`, `last` on the 4th, then a `frame_done` pulse, then `grant`=0.
- Round-robin fairness: `req`=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001. Each grant has exactly 4 words, and grants are 6 cycles apart.
- Backpressure: `out_ready` toggles 1,0,0,1,1,0,1 -> `word_en` only on high cycles, `last` on the 4th accepted word, counter held during stalls.
- Request drop: port 2 deasserts `req` after its 1st word -> 3 further words still sequenced, `frame_done` issued, next grant goes to the next requester after 2.
- Reset mid-packet: `reset` low after the 2nd word -> `grant`=0, `busy`=0 immediately with no `frame_done`. After release, `req`=1111 grants port 0 first.
- WORDS=1, NPORTS=2: `req`=11 -> `word_en` and `last` coincide on the first beat, and grants alternate 01, 10 every 3 cycles.
